// File: rtl/bus_arbiter_4_1_8_bit_v_pkg.sv
// Shared constants and helpers for the 4-requester round-robin bus arbiter.
package bus_arbiter_4_1_8_bit_v_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    localparam int unsigned NUM_REQ = 4;

    function automatic logic [3:0] onehot2(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Returns {found, index}: first set bit of req scanning last+1, last+2, ... wrapping mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] k;
        res = 3'b000;
        for (int i = 4; i >= 1; i--) begin
            k = last + 2'(i);
            if (req[k]) begin
                res = {1'b1, k};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bus_arbiter_4_1_8_bit_v_mux.sv
// 4:1 8-bit bus mux with tri-state output when disabled.
module MUX_4_1_8_bit_v (
    input  logic       i_en,
    input  logic [1:0] i_sel_code,
    input  logic [7:0] i_code_0,
    input  logic [7:0] i_code_1,
    input  logic [7:0] i_code_2,
    input  logic [7:0] i_code_3,
    output logic [7:0] o_code
);

    logic [7:0] w_sel;

    always_comb begin
        w_sel = i_code_0;
        case (i_sel_code)
            2'd0: w_sel = i_code_0;
            2'd1: w_sel = i_code_1;
            2'd2: w_sel = i_code_2;
            2'd3: w_sel = i_code_3;
            default: w_sel = i_code_0;
        endcase
    end

    assign o_code = i_en ? w_sel : 8'bzzzzzzzz;

endmodule

// File: rtl/bus_arbiter_4_1_8_bit_v.sv
// Round-robin arbiter with bounded hold time sharing one 8-bit bus between four requesters.
module bus_arbiter_4_1_8_bit_v
    import bus_arbiter_4_1_8_bit_v_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned HOLD_W   = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [7:0]         i_code_0,
    input  logic [7:0]         i_code_1,
    input  logic [7:0]         i_code_2,
    input  logic [7:0]         i_code_3,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [1:0]         o_sel_code,
    output logic               o_en,
    output logic [7:0]         o_code,
    output logic               o_busy
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);

    logic               r_state, w_state_nxt;
    logic [1:0]         r_ptr, w_ptr_nxt;
    logic [HOLD_W-1:0]  r_cnt, w_cnt_nxt;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
    logic [1:0]         r_sel, w_sel_nxt;
    logic               r_en, w_en_nxt;

    logic [NUM_REQ-1:0] w_others;
    logic [2:0]         w_pick_idle;
    logic [2:0]         w_pick_own;
    logic               w_take;
    logic [1:0]         w_take_idx;
    logic               w_release;

    // In IDLE r_grant is zero, so w_others is simply i_req.
    assign w_others    = i_req & ~r_grant;
    assign w_pick_idle = rr_pick(i_req, r_ptr);
    assign w_pick_own  = rr_pick(w_others, r_sel);

    always_comb begin
        w_take     = 1'b0;
        w_take_idx = r_sel;
        w_release  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_idle[2]) begin
                    w_take     = 1'b1;
                    w_take_idx = w_pick_idle[1:0];
                end
            end
            ST_GRANT: begin
                if (!i_req[r_sel]) begin
                    if (w_pick_own[2]) begin
                        w_take     = 1'b1;
                        w_take_idx = w_pick_own[1:0];
                    end else begin
                        w_release = 1'b1;
                    end
                end else if (w_pick_own[2] && (r_cnt >= HOLD_LAST)) begin
                    // Saturated counter also covers a requester arriving after the hold expired.
                    w_take     = 1'b1;
                    w_take_idx = w_pick_own[1:0];
                end
            end
            default: w_release = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        w_en_nxt    = r_en;
        w_cnt_nxt   = r_cnt;
        if ((r_state == ST_GRANT) && (r_cnt < HOLD_MAX)) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
        if (w_take) begin
            w_state_nxt = ST_GRANT;
            w_ptr_nxt   = w_take_idx;
            w_grant_nxt = onehot2(w_take_idx);
            w_sel_nxt   = w_take_idx;
            w_en_nxt    = 1'b1;
            w_cnt_nxt   = '0;
        end else if (w_release) begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
            w_en_nxt    = 1'b0;
            w_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd3;
            r_cnt   <= '0;
            r_grant <= '0;
            r_sel   <= 2'd0;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_grant <= w_grant_nxt;
            r_sel   <= w_sel_nxt;
            r_en    <= w_en_nxt;
        end
    end

    assign o_grant    = r_grant;
    assign o_sel_code = r_sel;
    assign o_en       = r_en;
    assign o_busy     = |w_others;

    MUX_4_1_8_bit_v u_mux (
        .i_en       (r_en),
        .i_sel_code (r_sel),
        .i_code_0   (i_code_0),
        .i_code_1   (i_code_1),
        .i_code_2   (i_code_2),
        .i_code_3   (i_code_3),
        .o_code     (o_code)
    );

endmodule

// File: tb/tb_bus_arbiter_4_1_8_bit_v.sv
// Bench for the round-robin bus arbiter: directed scenarios plus random traffic against a model.
module tb_bus_arbiter_4_1_8_bit_v;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] i_req;
    logic [7:0] codes [4];
    logic [3:0] o_grant;
    logic [1:0] o_sel_code;
    logic       o_en;
    wire  [7:0] o_code;
    logic       o_busy;

    int errors = 0;
    int checks = 0;

    // Model state: owner index (-1 = bus free), last granted index, cycles the owner has held.
    int m_owner;
    int m_ptr;
    int m_held;
    int m_sel;

    always #5 clk = ~clk;

    bus_arbiter_4_1_8_bit_v #(
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (4)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req      (i_req),
        .i_code_0   (codes[0]),
        .i_code_1   (codes[1]),
        .i_code_2   (codes[2]),
        .i_code_3   (codes[3]),
        .o_grant    (o_grant),
        .o_sel_code (o_sel_code),
        .o_en       (o_en),
        .o_code     (o_code),
        .o_busy     (o_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_next(input logic [3:0] req, input int after);
        for (int d = 1; d <= 4; d++) begin
            if (req[(after + d) % 4]) return (after + d) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_grant();
        return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 3;
        m_held  = 0;
        m_sel   = 0;
    endtask

    task automatic model_step(input logic [3:0] req);
        int         k;
        logic [3:0] others;
        if (m_owner < 0) begin
            k = rr_next(req, m_ptr);
            if (k >= 0) begin
                m_owner = k;
                m_held  = 1;
            end
        end else begin
            others = req & ~exp_grant();
            k = rr_next(others, m_owner);
            if (!req[m_owner]) begin
                m_owner = k;
                m_held  = 1;
            end else if (k >= 0 && m_held >= MAX_HOLD) begin
                m_owner = k;
                m_held  = 1;
            end else if (m_held < 1000) begin
                m_held++;
            end
        end
        if (m_owner >= 0) begin
            m_ptr = m_owner;
            m_sel = m_owner;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [7:0] e_code;
        e_code = 8'bzzzzzzzz;
        if (m_owner >= 0) e_code = codes[m_owner];
        chk({tag, ".grant"}, 32'(o_grant), 32'(exp_grant()));
        chk({tag, ".en"}, 32'(o_en), 32'(m_owner >= 0));
        chk({tag, ".sel"}, 32'(o_sel_code), 32'(m_sel));
        chk({tag, ".code"}, 32'(o_code), 32'(e_code));
    endtask

    // One clock: drive req at the falling edge, check busy, advance the model on the rising edge.
    task automatic cycle(input string tag, input logic [3:0] req);
        @(negedge clk);
        i_req = req;
        #1;
        chk({tag, ".busy"}, 32'(o_busy), 32'((req & ~exp_grant()) != 4'b0000));
        @(posedge clk);
        model_step(req);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        logic [3:0] r;
        for (int k = 0; k < 4; k++) codes[k] = 8'hA0 + 8'(k);
        rst   = 1'b1;
        i_req = 4'b0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_outputs("rst_idle");

        // Reset held with all requests pending: bus stays idle, then requester 0 wins first.
        @(negedge clk);
        i_req = 4'b1111;
        #1 check_outputs("rst_req");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        model_step(4'b1111);
        #1;
        chk("first_grant", 32'(o_grant), 32'h1);
        chk("first_code", 32'(o_code), 32'hA0);

        // Full contention: runs of MAX_HOLD cycles per owner in order 0,1,2,3,0.
        for (int i = 0; i < 4 * MAX_HOLD; i++) cycle("contend", 4'b1111);
        chk("contend_wrap", 32'(o_grant), 32'h1);

        // Single requester keeps the bus past counter saturation.
        cycle("drain", 4'b0000);
        for (int i = 0; i < 10; i++) cycle("single", 4'b0100);
        chk("single_kept", 32'(o_grant), 32'h4);
        cycle("single_drop", 4'b0000);
        cycle("single_idle", 4'b0000);

        // Back-to-back handoff from owner 1 searches rr from 1.
        cycle("own1", 4'b0010);
        cycle("own1", 4'b0010);
        cycle("handoff", 4'b1001);
        chk("handoff_grant", 32'(o_grant), 32'h8);
        cycle("drain", 4'b0000);

        // Late arrival preempts a saturated owner on the next edge.
        for (int i = 0; i < 8; i++) cycle("alone2", 4'b0100);
        cycle("late", 4'b0101);
        chk("late_grant", 32'(o_grant), 32'h1);
        cycle("drain", 4'b0000);

        // Asynchronous reset in the middle of owner 3's grant.
        cycle("own3", 4'b1000);
        cycle("own3", 4'b1000);
        chk("own3_grant", 32'(o_grant), 32'h8);
        @(negedge clk);
        i_req = 4'b1010;
        #2 rst = 1'b1;
        model_reset();
        #1 check_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        model_step(4'b1010);
        #1;
        chk("post_rst_grant", 32'(o_grant), 32'h2);

        // Random traffic with random bus data; requests change only some cycles.
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) r = 4'($urandom);
            if ($urandom_range(0, 7) == 0) codes[$urandom_range(0, 3)] = 8'($urandom);
            cycle("rand", r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bus_arbiter_4_1_8_bit_v.md
Name: bus_arbiter_4_1_8_bit_v

Overview:
Round-robin arbiter that shares one 8-bit output bus between four requesters.
- Drives the select code and enable of an internal 4:1 8-bit mux.
- Grants one requester at a time, with a bounded hold time, so no requester can starve the others.
- Sits in front of any shared 8-bit datapath consumer; the consumer sees a tri-stated bus whenever no requester owns it.

Parameters:
MAX_HOLD, 4, max consecutive cycles one owner keeps the bus while others are waiting; legal range 1..15.
HOLD_W, 4, width of the hold counter; must satisfy 2**HOLD_W > MAX_HOLD.

Ports:
i_clk  input  1  clock; all state changes on the rising edge.
i_rst  input  1  reset; asynchronous, active-high.
i_req  input  4  request per requester; bit k = requester k.
i_code_0  input  8  data from requester 0.
i_code_1  input  8  data from requester 1.
i_code_2  input  8  data from requester 2.
i_code_3  input  8  data from requester 3.
o_grant  output  4  one-hot grant, registered; all zero when idle.
o_sel_code  output  2  index of the current owner, registered.
o_en  output  1  bus enable, registered; 1 exactly when o_grant != 0.
o_code  output  8  shared bus = selected i_code_k when o_en=1, else 8'bZZZZZZZZ (combinational from registered sel/en).
o_busy  output  1  1 when requesters other than the owner are pending (i_req & ~o_grant != 0), combinational.

Behaviour:
- Reset (async, any time, including mid-grant):
  - o_grant=0, o_sel_code=2'b00, o_en=0, o_code=Z.
  - State=IDLE, hold counter=0, rr pointer=3, so requester 0 has top priority after reset.
- Round-robin search: start at pointer+1, wrap mod 4, pick the first k with i_req[k]=1. On every new grant, pointer <= granted index.
- State IDLE:
  - If i_req==0: stay IDLE; outputs idle.
  - If i_req!=0: on the next edge go to GRANT.
    - o_grant=onehot(k), o_sel_code=k, o_en=1, counter=0.
  - Latency: request to bus ownership is 1 cycle.
- State GRANT (owner j):
  - Counter increments each cycle the owner is held; it saturates at MAX_HOLD.
  - Release, when i_req[j]=0:
    - If another request is pending, switch on the next edge directly to the next rr winner searched from j (no idle bubble); counter=0.
    - Otherwise go to IDLE; o_en=0, o_grant=0.
    - o_sel_code holds its last value while idle.
  - Forced rotation: when counter==MAX_HOLD-1, i_req[j]=1 and (i_req & ~onehot(j))!=0, switch on the next edge to the next rr winner; counter=0.
    - The preempted owner keeps its request and is served again in rr order.
  - Uncontended hold: if counter reaches its limit and no other request is pending, j keeps the bus and the counter holds at its limit.
    - A later-arriving requester then preempts j on the edge after it appears.
  - Requests from non-owners never alter the current grant except through forced rotation or release.
- Simultaneous owner release and new requests in the same cycle are handled by the release rule, searching rr from j.
- A requester whose i_req drops before it is granted is simply skipped; no request memory.
- o_grant is always one-hot or zero; o_sel_code always equals the index of the set bit when o_en=1.
- MAX_HOLD=1: every contended cycle rotates.

Decomposition:
- Shared include (bus_arb_defs_v.vh):
  - State encodings ST_IDLE=1'b0, ST_GRANT=1'b1.
  - Constant NUM_REQ=4.
  - Function onehot2 (2-bit index to 4-bit one-hot).
- Sub-module: instantiate the existing MUX_4_1_8_bit_v for the bus.
  - i_en=o_en, i_sel_code=o_sel_code, o_code to the output.
  - The arbiter contains the FSM, rr pointer, hold counter and rr search only.

Test Plan:
- Reset: assert i_rst mid-cycle with i_req=4'b1111 -> o_grant=0, o_en=0, o_code=8'hZZ immediately. Release reset -> next edge o_grant=4'b0001, o_code=8'hA0 (inputs i_code_k=8'hA0+k).
- Single requester: i_req=4'b0100 for 10 cycles, then 0 -> grant 4'b0100 from cycle 1 through the cycle after drop. Never preempted despite the counter saturating. Then IDLE, o_code=Z.
- Full contention, MAX_HOLD=4, i_req=4'b1111 held -> grants 0,1,2,3,0 in runs of exactly 4 cycles each. o_code sequence A0,A1,A2,A3,A0. o_busy=1 throughout.
- Back-to-back handoff: owner 1 drops i_req[1] while i_req=4'b1001 -> next edge grant 4'b1000 (rr from 1 picks 3, not 0), no idle cycle.
- Late arrival: owner 2 alone for 8 cycles (counter saturated), then i_req[0] rises -> next edge grant moves to 0.
- Reset mid-grant: owner 3 active, pulse i_rst -> outputs idle asynchronously. After release, with i_req=4'b1010 -> grant 4'b0010 (pointer back to 3).
